// File: rtl/riscv_pkg.sv
// Shared FP writeback types: request record and default skid depth.
package riscv_pkg;

  localparam int FP_WB_FIFO_DEPTH = 4;

  typedef struct packed {
    logic        valid;
    logic [4:0]  dest;
    logic [31:0] data;
    logic [4:0]  fflags;
  } fp_wb_req_t;

endpackage

// File: rtl/fp_wb_fifo.sv
// Synchronous skid FIFO with an occupancy count and a sticky overflow flag.
module fp_wb_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign head     = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

  // Next-state for pointers/count; a push into a full FIFO is only legal with a same-cycle pop.
  always_comb begin
    do_push    = push && (!full || pop);
    do_pop     = pop && !empty;
    wr_ptr_d   = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d    = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
    overflow_d = overflow_q | (push & full & ~pop);
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP regfile writeback arbiter: load > skid FIFO head > fresh pipe > div/sqrt.
module fp_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int FIFO_DEPTH  = FP_WB_FIFO_DEPTH,
  parameter int HOLD_THRESH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_ld_valid,
  input  logic [4:0]  i_ld_dest,
  input  logic [31:0] i_ld_data,
  input  logic        i_pipe_valid,
  input  logic [4:0]  i_pipe_dest,
  input  logic [31:0] i_pipe_data,
  input  logic [4:0]  i_pipe_fflags,
  input  logic        i_ds_valid,
  input  logic [4:0]  i_ds_dest,
  input  logic [31:0] i_ds_data,
  input  logic [4:0]  i_ds_fflags,
  output logic        o_ds_ready,
  output logic        o_wr_en,
  output logic [4:0]  o_wr_dest,
  output logic [31:0] o_wr_data,
  output logic        o_fflags_valid,
  output logic [4:0]  o_fflags,
  output logic        o_fpu_issue_hold
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = $bits(fp_wb_req_t);

  fp_wb_req_t        ld_req, pipe_req, ds_req, head_req;
  fp_wb_req_t        out_q, out_d;
  logic              ffv_q, ffv_d;
  logic              fifo_push, fifo_pop, fifo_empty, fifo_full, fifo_overflow;
  logic [RW-1:0]     fifo_head;
  logic [CW-1:0]     fifo_count;
  logic [31:0]       occ;
  logic              ds_ready_c;

  assign ld_req   = '{valid: i_ld_valid,   dest: i_ld_dest,   data: i_ld_data,   fflags: 5'd0};
  assign pipe_req = '{valid: i_pipe_valid, dest: i_pipe_dest, data: i_pipe_data, fflags: i_pipe_fflags};
  assign ds_req   = '{valid: i_ds_valid,   dest: i_ds_dest,   data: i_ds_data,   fflags: i_ds_fflags};
  assign head_req = fp_wb_req_t'(fifo_head);

  fp_wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(RW)) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .push     (fifo_push),
    .push_data(pipe_req),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count),
    .overflow (fifo_overflow)
  );

  // Grant selection; a pipe result that does not go straight out is parked in the FIFO.
  always_comb begin
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    ds_ready_c = 1'b0;
    out_d      = out_q;
    ffv_d      = ffv_q;
    if (i_stall) begin
      fifo_push = i_pipe_valid;
    end else if (i_ld_valid) begin
      out_d     = ld_req;
      ffv_d     = 1'b0;
      fifo_push = i_pipe_valid;
    end else if (!fifo_empty) begin
      out_d     = head_req;
      ffv_d     = 1'b1;
      fifo_pop  = 1'b1;
      fifo_push = i_pipe_valid;
    end else if (i_pipe_valid) begin
      out_d = pipe_req;
      ffv_d = 1'b1;
    end else begin
      ds_ready_c = 1'b1;
      out_d      = ds_req;
      ffv_d      = i_ds_valid;
    end
  end

  // Registered write port; holds while stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_q <= '0;
      ffv_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ffv_q <= ffv_d;
    end
  end

  assign occ              = 32'(fifo_count);
  assign o_fpu_issue_hold = !i_rst && (occ >= 32'(HOLD_THRESH));
  assign o_ds_ready       = ds_ready_c && !i_rst;
  assign o_wr_en          = out_q.valid;
  assign o_wr_dest        = out_q.dest;
  assign o_wr_data        = out_q.data;
  assign o_fflags_valid   = out_q.valid && ffv_q;
  assign o_fflags         = ffv_q ? out_q.fflags : 5'd0;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed bench for fp_wb_arbiter plus a short ordered-traffic scoreboard run.
module tb_fp_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst, i_stall;
  logic        i_ld_valid;
  logic [4:0]  i_ld_dest;
  logic [31:0] i_ld_data;
  logic        i_pipe_valid;
  logic [4:0]  i_pipe_dest;
  logic [31:0] i_pipe_data;
  logic [4:0]  i_pipe_fflags;
  logic        i_ds_valid;
  logic [4:0]  i_ds_dest;
  logic [31:0] i_ds_data;
  logic [4:0]  i_ds_fflags;
  logic        o_ds_ready, o_wr_en, o_fflags_valid, o_fpu_issue_hold;
  logic [4:0]  o_wr_dest, o_fflags;
  logic [31:0] o_wr_data;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  fp_wb_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall),
    .i_ld_valid(i_ld_valid), .i_ld_dest(i_ld_dest), .i_ld_data(i_ld_data),
    .i_pipe_valid(i_pipe_valid), .i_pipe_dest(i_pipe_dest),
    .i_pipe_data(i_pipe_data), .i_pipe_fflags(i_pipe_fflags),
    .i_ds_valid(i_ds_valid), .i_ds_dest(i_ds_dest),
    .i_ds_data(i_ds_data), .i_ds_fflags(i_ds_fflags),
    .o_ds_ready(o_ds_ready), .o_wr_en(o_wr_en), .o_wr_dest(o_wr_dest),
    .o_wr_data(o_wr_data), .o_fflags_valid(o_fflags_valid),
    .o_fflags(o_fflags), .o_fpu_issue_hold(o_fpu_issue_hold)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_stall = 0; i_ld_valid = 0; i_pipe_valid = 0; i_ds_valid = 0;
    i_ld_dest = 0; i_ld_data = 0; i_pipe_dest = 0; i_pipe_data = 0;
    i_pipe_fflags = 0; i_ds_dest = 0; i_ds_data = 0; i_ds_fflags = 0;
  endtask

  task automatic pipe(input logic [4:0] d, input logic [31:0] v, input logic [4:0] f);
    i_pipe_valid = 1; i_pipe_dest = d; i_pipe_data = v; i_pipe_fflags = f;
  endtask

  task automatic wr(input string tag, input logic en, input logic [4:0] d,
                    input logic [31:0] v, input logic ffv, input logic [4:0] f);
    chk({tag, "_en"},   o_wr_en, en);
    chk({tag, "_dest"}, o_wr_dest, d);
    chk({tag, "_data"}, o_wr_data, v);
    chk({tag, "_ffv"},  o_fflags_valid, ffv);
    chk({tag, "_ff"},   o_fflags, f);
  endtask

  logic [41:0] ld_q[$];
  logic [41:0] pipe_q[$];

  initial begin
    idle();
    // reset with a pending div/sqrt result
    i_rst = 1; i_ds_valid = 1; i_ds_dest = 9;
    tick(); tick();
    wr("rst", 0, 0, 0, 0, 0);
    chk("rst_cnt",   dut.fifo_count, 0);
    chk("rst_hold",  o_fpu_issue_hold, 0);
    chk("rst_dsrdy", o_ds_ready, 0);
    i_rst = 0; idle();
    tick();
    chk("idle_en",    o_wr_en, 0);
    chk("idle_dsrdy", o_ds_ready, 1);

    // lone pipe result goes straight through
    pipe(3, 32'h3F80_0000, 5'h01);
    tick(); idle();
    wr("lone", 1, 3, 32'h3F80_0000, 1, 5'h01);
    chk("lone_cnt", dut.fifo_count, 0);
    tick();
    chk("lone_after_en", o_wr_en, 0);

    // load beats pipe; pipe drains from FIFO next cycle
    i_ld_valid = 1; i_ld_dest = 5; i_ld_data = 32'h1111_1111;
    pipe(6, 32'h2222_2222, 5'h04);
    tick(); idle();
    wr("ldpipe_ld", 1, 5, 32'h1111_1111, 0, 0);
    chk("ldpipe_cnt1", dut.fifo_count, 1);
    tick();
    wr("ldpipe_pipe", 1, 6, 32'h2222_2222, 1, 5'h04);
    chk("ldpipe_cnt0", dut.fifo_count, 0);
    tick();

    // div/sqrt waits behind three pipe results
    i_ds_valid = 1; i_ds_dest = 7; i_ds_data = 32'h4000_0000; i_ds_fflags = 5'h02;
    for (int k = 0; k < 3; k++) begin
      pipe(5'(10 + k), 32'hA0 + 32'(k), 0);
      #1 chk("ds_block", o_ds_ready, 0);
      tick();
      wr("ds_pipe", 1, 5'(10 + k), 32'hA0 + 32'(k), 1, 0);
    end
    i_pipe_valid = 0;
    #1 chk("ds_accept", o_ds_ready, 1);
    tick(); i_ds_valid = 0;
    wr("ds_wr", 1, 7, 32'h4000_0000, 1, 5'h02);
    tick();
    chk("ds_once", o_wr_en, 0);

    // stall freezes output while pipe results pile up
    pipe(19, 32'h19, 0);
    tick();
    i_stall = 1; i_ds_valid = 1; i_ds_dest = 8;
    for (int k = 0; k < 3; k++) begin
      pipe(5'(20 + k), 32'h20 + 32'(k), 5'(k + 1));
      #1 chk("stall_dsrdy", o_ds_ready, 0);
      tick();
      wr("stall_frz", 1, 19, 32'h19, 1, 0);
      chk("stall_cnt", dut.fifo_count, k + 1);
    end
    chk("stall_hold", o_fpu_issue_hold, 1);
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      wr("drain", 1, 5'(20 + k), 32'h20 + 32'(k), 1, 5'(k + 1));
    end
    chk("drain_cnt", dut.fifo_count, 0);
    chk("drain_hold", o_fpu_issue_hold, 0);

    // reset with occupancy 2 and a pending div/sqrt
    i_stall = 1;
    pipe(25, 32'h25, 0); tick();
    pipe(26, 32'h26, 0); tick();
    chk("prerst_cnt", dut.fifo_count, 2);
    i_rst = 1; i_stall = 0; i_ds_valid = 1; i_ds_dest = 30; i_ds_data = 32'hDEAD;
    pipe(31, 32'hBEEF, 1);
    tick();
    wr("rst2", 0, 0, 0, 0, 0);
    chk("rst2_cnt",  dut.fifo_count, 0);
    chk("rst2_hold", o_fpu_issue_hold, 0);
    i_rst = 0; idle();
    tick();
    chk("rst2_nowr", o_wr_en, 0);

    // ordered traffic honouring hold: loads and pipe results each keep their order
    for (int c = 0; c < 60; c++) begin
      idle();
      if ($urandom_range(0, 1) == 1) begin
        i_ld_valid = 1; i_ld_dest = 5'(c); i_ld_data = 32'hA000_0000 + 32'(c);
        ld_q.push_back({i_ld_dest, i_ld_data, 5'd0});
      end
      if (!o_fpu_issue_hold && $urandom_range(0, 2) != 0) begin
        pipe(5'(c + 1), 32'hB000_0000 + 32'(c), 5'(c));
        pipe_q.push_back({i_pipe_dest, i_pipe_data, i_pipe_fflags});
      end
      tick();
      if (o_wr_en) begin
        if (!o_fflags_valid) begin
          chk("rnd_ld_avail", ld_q.size() != 0, 1);
          if (ld_q.size() != 0) chk("rnd_ld", {o_wr_dest, o_wr_data, o_fflags}, ld_q.pop_front());
        end else begin
          chk("rnd_pipe_avail", pipe_q.size() != 0, 1);
          if (pipe_q.size() != 0) chk("rnd_pipe", {o_wr_dest, o_wr_data, o_fflags}, pipe_q.pop_front());
        end
      end
    end
    idle();
    for (int c = 0; c < 8; c++) begin
      tick();
      if (o_wr_en && o_fflags_valid && pipe_q.size() != 0)
        chk("rnd_drain", {o_wr_dest, o_wr_data, o_fflags}, pipe_q.pop_front());
    end
    chk("rnd_ld_left",   ld_q.size(), 0);
    chk("rnd_pipe_left", pipe_q.size(), 0);
    chk("overflow", dut.fifo_overflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_wb_arbiter.md
FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, skid-FIFO entries for pipelined-FPU results that lose arbitration.
REQ-002 Parameter HOLD_THRESH, default 2, FIFO occupancy at or above which o_fpu_issue_hold asserts.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_stall  input  1  pipeline stall (pipeline_ctrl.stall).
REQ-006 i_ld_valid / i_ld_dest / i_ld_data  input  1/5/32  FLW result from MA; held by MA while stalled.
REQ-007 i_pipe_valid / i_pipe_dest / i_pipe_data / i_pipe_fflags  input  1/5/32/5  pipelined FPU (add/mul/FMA/convert) completion; cannot be back-pressured.
REQ-008 i_ds_valid / i_ds_dest / i_ds_data / i_ds_fflags  input  1/5/32/5  iterative div/sqrt completion.
REQ-009 o_ds_ready  output  1  div/sqrt result accepted this cycle when high with i_ds_valid.
REQ-010 o_wr_en / o_wr_dest / o_wr_data  output  1/5/32  registered FP regfile write port (fp_regfile_write_enable, fp_dest_reg, fp_regfile_write_data).
REQ-011 o_fflags_valid / o_fflags  output  1/5  exception flags of the write in flight, for fcsr accrual.
REQ-012 o_fpu_issue_hold  output  1  blocks issue of new pipelined/div-sqrt FP ops.

Function
REQ-013 Exactly one write per cycle; grant computed only when i_stall=0.
REQ-014 Priority: load > FIFO head > fresh pipe result > div/sqrt.
REQ-015 Fresh pipe result goes direct to output only when FIFO empty and no load; otherwise it is enqueued in the same cycle.
REQ-016 While i_stall=1, a valid pipe result is enqueued, o_ds_ready=0, load is not consumed, output registers hold.
REQ-017 o_ds_ready=1 iff i_stall=0, no load, FIFO empty, no fresh pipe valid; div/sqrt data must stay stable until accepted.
REQ-018 Grant latency: winner appears on o_wr_* the next cycle; o_wr_en=0 when no grant.
REQ-019 o_fflags_valid mirrors o_wr_en for pipe/div-sqrt writes; 0 for load writes (fflags=0).
REQ-020 FIFO preserves completion order; simultaneous enqueue and dequeue leaves occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-021 o_fpu_issue_hold = (occupancy >= HOLD_THRESH), combinational from registered count.
REQ-022 Enqueue into a full FIFO is a design error; result dropped, sticky internal overflow flag set for assertion checking.
REQ-023 No flush input: every FP op reaching this block is non-speculative and is written.
REQ-024 Same-dest back-to-back writes are emitted in grant order; no merging.

Reset
REQ-025 On i_rst: o_wr_en=0, o_wr_dest=0, o_wr_data=0, o_fflags_valid=0, o_fflags=0, FIFO empty, pointers 0, overflow flag 0.
REQ-026 Reset overrides stall and any in-flight input; inputs present during reset are discarded.
REQ-027 o_ds_ready=0 and o_fpu_issue_hold=0 during reset.

Structure
REQ-028 riscv_pkg gains fp_wb_req_t {valid, dest[4:0], data[31:0], fflags[4:0]} and FP_WB_FIFO_DEPTH constant.
REQ-029 Skid buffer is one sub-module, fp_wb_fifo (synchronous FIFO, count output, parameterised depth/width).
REQ-030 Arbiter logic and output register stay in fp_wb_arbiter.

Verification
REQ-031 Lone pipe result dest=3 data=0x3F800000 fflags=0x01 -> next cycle o_wr_en=1, dest=3, data=0x3F800000, o_fflags_valid=1, o_fflags=0x01.
REQ-032 Load dest=5 and pipe dest=6 same cycle -> load written cycle N+1, pipe (from FIFO) N+2, FIFO empty after.
REQ-033 Div/sqrt valid dest=7 with pipe results 3 consecutive cycles -> o_ds_ready=0 for those cycles plus FIFO drain, then accepted, written once.
REQ-034 i_stall=1 for 3 cycles with pipe valid each cycle -> o_wr_* frozen, occupancy 3, hold=1; after release, results written in order over 3 cycles.
REQ-035 i_rst asserted with occupancy 2 and ds valid -> next cycle o_wr_en=0, occupancy 0, hold=0, no write of discarded data.
REQ-036 Random legal traffic honouring hold -> overflow flag never set; write sequence equals reference model order.
